mem_req_sequencer: RTL and testbench
====================================

Name: mem_req_sequencer

Overview:
- Upstream command stage for the memory block. Accepts read/write requests over a valid/ready handshake and drives the memory's WrEn/RdEn/Addr/WrBus/RdEn_Opcode/BitAddr/ByteAddr pins one command per cycle.
- Captures RdBus after a fixed read latency and returns it through a backpressured response FIFO.
- Has a built-in fill engine that writes a pattern across the whole address space (power-up init / test preload).

Parameters:
- AW, 16, memory address width.
- DW, 32, data width.
- RD_LAT, 2, cycles from mem_rden asserted to valid mem_rdbus (range 1..4).
- RSP_DEPTH, 4, response FIFO entries (power of 2, at least RD_LAT).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  word address.
- req_wdata  in  DW  write data.
- req_opcode  in  2  read opcode, passed to RdEn_Opcode unchanged.
- req_bitaddr  in  5  passed to BitAddr.
- req_byteaddr  in  2  passed to ByteAddr.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DW  read data.
- rsp_addr  out  AW  address of that read.
- fill_start  in  1  one-cycle pulse that starts a fill.
- fill_pattern  in  1  0 = data equals address; 1 = walking one, data = 1 << (addr mod DW).
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse when the fill completes.
- err_count  out  16  readback mismatches (see Optional Feature).
- mem_wren, mem_rden  out  1  to memory WrEn/RdEn.
- mem_addr  out  AW  to Addr.
- mem_wrbus  out  DW  to WrBus.
- mem_opcode  out  2  to RdEn_Opcode.
- mem_bitaddr  out  5  to BitAddr.
- mem_byteaddr  out  2  to ByteAddr.
- mem_rdbus  in  DW  from RdBus.

Behaviour:
- Reset: every output 0, FSM to IDLE, FIFO flushed, in-flight reads discarded, err_count 0. A reset mid-fill or mid-read aborts the operation and produces no fill_done and no response.
- Memory outputs are registered. An accepted request appears on mem_* on the next cycle for exactly one cycle.
- mem_wren and mem_rden are never high together. Both are 0 in idle cycles, and mem_addr/mem_wrbus hold their last values.
- Read tracking: a RD_LAT-deep valid/address shift register runs alongside the read. On slot exit, {mem_rdbus, addr} is pushed into the response FIFO.
- Credits: credits = RSP_DEPTH − fifo_count − inflight. A read is accepted only while credits > 0, so the FIFO never overflows. Writes need no credit.
- req_ready = (state == IDLE) and (req_write or credits > 0). req_ready never depends combinationally on req_valid.
- Responses leave in issue order. rsp_valid/rsp_data/rsp_addr are stable while rsp_valid is high and rsp_ready is low. Push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, FILL, DRAIN.
  - IDLE: fill_start moves to DRAIN; req_ready drops the same cycle.
  - DRAIN: waits for inflight == 0, then moves to FILL with counter = 0.
  - FILL: issues one write per cycle with addr = counter and data per fill_pattern (pattern latched at fill_start). After address 2^AW−1 it pulses fill_done and returns to IDLE. The counter wraps to 0.
  - fill_busy is high in DRAIN and FILL.
  - fill_start is ignored outside IDLE. If fill_start and req_valid arrive together, fill wins and the request is not accepted.
- Fill length: 2^AW write cycles plus the drain.

Optional Feature:
- Macro MEM_REQ_SEQ_READBACK_EN.
- Defined: after the fill writes, the FSM enters VERIFY and reads every address at one per cycle. Read data goes to an internal comparator, not the response FIFO. Each word that differs from the expected pattern increments err_count, which saturates at 16'hFFFF. fill_done pulses after the last comparison, and fill_busy stays high through VERIFY. err_count clears at each fill_start.
- Undefined: no VERIFY state; err_count is tied to 0.

Decomposition:
- Package mem_req_pkg holds AW/DW defaults, the state enum (IDLE, DRAIN, FILL, VERIFY), the fill-pattern enum (PAT_ADDR, PAT_WALK1), and the function fill_data(addr, pat).
- Sub-module mem_req_rsp_fifo: synchronous FIFO with count output, parameterised depth and width (DW+AW).

Test Plan:
- Reset held 3 cycles, then released → all outputs 0, req_ready=1, rsp_valid=0.
- Write addr 0x0005 data 0x1234_5678, then read 0x0005 with opcode 0, bitaddr 7 → one mem_wren pulse then one mem_rden pulse; rsp_data equals the model RdBus, rsp_addr = 0x0005, RD_LAT+1 cycles after acceptance.
- 8 back-to-back reads with rsp_ready=0 → exactly RSP_DEPTH accepted, then req_ready=0; raising rsp_ready drains them in order 0..3 and acceptance resumes.
- fill_start with pattern 0, AW=16 → 65536 writes with data = addr, fill_done after the last one; model memory at addr 0xFFFF holds 0x0000FFFF.
- Pattern 1 fill with READBACK_EN defined, memory model corrupting addr 0x0040 → VERIFY completes with err_count = 1; the same run without corruption gives err_count = 0.
- Reset asserted in the middle of a fill and of an in-flight read → no fill_done, no rsp_valid; req_ready=1 on the cycle after reset drops.

Source files
------------

// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared types and helpers for the memory request sequencer.
//   AW_DEF / DW_DEF : default address / data widths
//   state_t         : sequencer FSM states (IDLE, DRAIN, FILL, VERIFY)
//   pat_t           : fill pattern select (PAT_ADDR, PAT_WALK1)
//   fill_data()     : word written by the fill engine at a given address
package mem_req_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    FILL   = 2'd2,
    VERIFY = 2'd3
  } state_t;

  typedef enum logic {
    PAT_ADDR  = 1'b0,
    PAT_WALK1 = 1'b1
  } pat_t;

  // Callers truncate the 64-bit result to their data width.
  function automatic logic [63:0] fill_data(input logic [63:0] addr, input pat_t pat,
                                            input int unsigned dw = DW_DEF);
    logic [63:0] pos;
    pos = addr % 64'(dw);
    if (pat == PAT_WALK1) return 64'd1 << pos;
    return addr;
  endfunction

endpackage

// File: rtl/mem_req_rsp_fifo.sv
// mem_req_rsp_fifo: synchronous FIFO holding read responses {data, addr}.
//   clk, reset        : clock, synchronous active-high reset (flushes contents)
//   push, push_data   : write one entry (caller guarantees not full)
//   pop, pop_data     : consume head entry (caller guarantees not empty)
//   valid             : FIFO non-empty; pop_data is the head entry
//   count             : number of stored entries
module mem_req_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          valid,
  output logic [PW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign valid    = (count != '0);

endmodule

// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: command stage in front of the memory block.
//   Requests (req_*) are accepted on a valid/ready handshake and issued as
//   registered one-cycle commands on mem_*. Reads return through a
//   backpressured response FIFO (rsp_*) in issue order. A fill engine
//   (fill_start/fill_pattern/fill_busy/fill_done) writes a pattern to every
//   address.
//   Optional build macro MEM_REQ_SEQ_READBACK_EN: after filling, every
//   address is read back and compared; mismatches are counted in err_count.
//   Without the macro err_count is constant 0.
//   clk, reset (sync, active-high); mem_rdbus valid RD_LAT cycles after mem_rden.
module mem_req_sequencer
  import mem_req_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int RD_LAT    = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [1:0]    req_opcode,
  input  logic [4:0]    req_bitaddr,
  input  logic [1:0]    req_byteaddr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  input  logic          fill_start,
  input  logic          fill_pattern,
  output logic          fill_busy,
  output logic          fill_done,
  output logic [15:0]   err_count,
  output logic          mem_wren,
  output logic          mem_rden,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wrbus,
  output logic [1:0]    mem_opcode,
  output logic [4:0]    mem_bitaddr,
  output logic [1:0]    mem_byteaddr,
  input  logic [DW-1:0] mem_rdbus
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int OW = $clog2(RSP_DEPTH + RD_LAT + 2) + 1;

  state_t        state, state_d;
  logic [AW-1:0] cnt, cnt_d;
  pat_t          pat, pat_d;

  logic          wren_d, rden_d, done_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wrbus_d;
  logic [1:0]    opcode_d;
  logic [4:0]    bit_d;
  logic [1:0]    byte_d;

  logic [RD_LAT-1:0] vld_p;
  logic [AW-1:0]     addr_p [RD_LAT];
  logic              exit_vld;
  logic [AW-1:0]     exit_addr;

  logic [CW-1:0]     fifo_count;
  logic [OW-1:0]     inflight;
  logic              read_ok;
  logic              push, pop, fifo_valid;
  logic [DW+AW-1:0]  fifo_out;

`ifdef MEM_REQ_SEQ_READBACK_EN
  logic              vfy_rd, vfy_d;
  logic [RD_LAT-1:0] vfy_p;
  logic              issued, issued_d;
  logic              cmp_err, cmp_last;
  logic [15:0]       err_q;
`endif

  // Reads not yet in the FIFO: the issue cycle plus every tracking slot.
  always_comb begin
    inflight = OW'(mem_rden);
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OW'(vld_p[i]);
  end

  assign read_ok   = (OW'(fifo_count) + inflight) < OW'(RSP_DEPTH);
  assign req_ready = (state == IDLE) && !fill_start && (req_write || read_ok);
  assign fill_busy = (state != IDLE);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    pat_d    = pat;
    wren_d   = 1'b0;
    rden_d   = 1'b0;
    done_d   = 1'b0;
    addr_d   = mem_addr;
    wrbus_d  = mem_wrbus;
    opcode_d = mem_opcode;
    bit_d    = mem_bitaddr;
    byte_d   = mem_byteaddr;
`ifdef MEM_REQ_SEQ_READBACK_EN
    vfy_d    = 1'b0;
    issued_d = issued;
`endif
    case (state)
      IDLE: begin
        if (fill_start) begin
          state_d = DRAIN;
          pat_d   = pat_t'(fill_pattern);
        end else if (req_valid && req_ready) begin
          wren_d   = req_write;
          rden_d   = !req_write;
          addr_d   = req_addr;
          opcode_d = req_opcode;
          bit_d    = req_bitaddr;
          byte_d   = req_byteaddr;
          if (req_write) wrbus_d = req_wdata;
        end
      end
      DRAIN: begin
        if (inflight == '0) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        wren_d  = 1'b1;
        addr_d  = cnt;
        wrbus_d = DW'(fill_data(64'(cnt), pat, DW));
        cnt_d   = cnt + 1'b1;
        if (&cnt) begin
`ifdef MEM_REQ_SEQ_READBACK_EN
          state_d  = VERIFY;
          issued_d = 1'b0;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef MEM_REQ_SEQ_READBACK_EN
      VERIFY: begin
        if (!issued) begin
          rden_d   = 1'b1;
          vfy_d    = 1'b1;
          addr_d   = cnt;
          opcode_d = 2'd0;
          cnt_d    = cnt + 1'b1;
          if (&cnt) issued_d = 1'b1;
        end
        // Finish only once the last read-back word has been compared.
        if (cmp_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Command stage: registered memory pins and FSM state
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      pat          <= PAT_ADDR;
      mem_wren     <= 1'b0;
      mem_rden     <= 1'b0;
      mem_addr     <= '0;
      mem_wrbus    <= '0;
      mem_opcode   <= '0;
      mem_bitaddr  <= '0;
      mem_byteaddr <= '0;
      fill_done    <= 1'b0;
`ifdef MEM_REQ_SEQ_READBACK_EN
      vfy_rd       <= 1'b0;
      issued       <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      pat          <= pat_d;
      mem_wren     <= wren_d;
      mem_rden     <= rden_d;
      mem_addr     <= addr_d;
      mem_wrbus    <= wrbus_d;
      mem_opcode   <= opcode_d;
      mem_bitaddr  <= bit_d;
      mem_byteaddr <= byte_d;
      fill_done    <= done_d;
`ifdef MEM_REQ_SEQ_READBACK_EN
      vfy_rd       <= vfy_d;
      issued       <= issued_d;
`endif
    end
  end

  // Read tracking stages p0..p(RD_LAT-1): slot exit lines up with valid mem_rdbus
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= mem_rden;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    addr_p[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) addr_p[i] <= addr_p[i-1];
  end

  assign exit_vld  = vld_p[RD_LAT-1];
  assign exit_addr = addr_p[RD_LAT-1];

`ifdef MEM_REQ_SEQ_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      vfy_p <= '0;
    end else begin
      vfy_p[0] <= vfy_rd;
      for (int i = 1; i < RD_LAT; i++) vfy_p[i] <= vfy_p[i-1];
    end
  end

  assign cmp_err  = exit_vld && vfy_p[RD_LAT-1] &&
                    (mem_rdbus != DW'(fill_data(64'(exit_addr), pat, DW)));
  assign cmp_last = exit_vld && vfy_p[RD_LAT-1] && (&exit_addr);

  always_ff @(posedge clk) begin
    if (reset)                           err_q <= '0;
    else if (state == IDLE && fill_start) err_q <= '0;
    else if (cmp_err && !(&err_q))       err_q <= err_q + 16'd1;
  end

  assign err_count = err_q;
  // Read-back words go to the comparator only, never to the response FIFO.
  assign push      = exit_vld && !vfy_p[RD_LAT-1];
`else
  assign err_count = '0;
  assign push      = exit_vld;
`endif

  // Response stage: FIFO head drives rsp_*
  assign pop = fifo_valid && rsp_ready;

  mem_req_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (DW + AW)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({mem_rdbus, exit_addr}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign rsp_valid            = fifo_valid;
  assign {rsp_data, rsp_addr} = fifo_valid ? fifo_out : '0;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb_mem_req_sequencer: directed bench for mem_req_sequencer with a
// behavioural memory (RD_LAT = 2 read pipeline, optional word corruption).
// With MEM_REQ_SEQ_READBACK_EN defined the bench uses AW = 8 so the
// fill + verify passes stay short; otherwise AW = 16.
module tb_mem_req_sequencer;
  import mem_req_pkg::*;

`ifdef MEM_REQ_SEQ_READBACK_EN
  localparam int AW = 8;
`else
  localparam int AW = 16;
`endif
  localparam int DW        = 32;
  localparam int RD_LAT    = 2;
  localparam int RSP_DEPTH = 4;
  localparam int NWORDS    = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_opcode, req_byteaddr;
  logic [4:0]    req_bitaddr;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          fill_start, fill_pattern, fill_busy, fill_done;
  logic [15:0]   err_count;
  logic          mem_wren, mem_rden;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wrbus, mem_rdbus;
  logic [1:0]    mem_opcode, mem_byteaddr;
  logic [4:0]    mem_bitaddr;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, both_cnt = 0;
  int acc;
  int snap_wr, snap_done, n;

  always #5 clk = ~clk;

  mem_req_sequencer #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_opcode(req_opcode),
    .req_bitaddr(req_bitaddr), .req_byteaddr(req_byteaddr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
    .fill_start(fill_start), .fill_pattern(fill_pattern), .fill_busy(fill_busy),
    .fill_done(fill_done), .err_count(err_count),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_wrbus(mem_wrbus),
    .mem_opcode(mem_opcode), .mem_bitaddr(mem_bitaddr), .mem_byteaddr(mem_byteaddr),
    .mem_rdbus(mem_rdbus)
  );

  // Memory model: synchronous write, two-stage read pipeline.
  logic [DW-1:0] mem [NWORDS];
  logic [DW-1:0] rd_p0, rd_p1;
  logic          corrupt = 1'b0;

  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_wrbus;
    if (mem_rden) rd_p0 <= (corrupt && mem_addr == AW'(16'h0040)) ? ~mem[mem_addr] : mem[mem_addr];
    rd_p1 <= rd_p0;
  end
  assign mem_rdbus = rd_p1;

  always @(posedge clk) begin
    wr_cnt   <= wr_cnt + int'(mem_wren);
    rd_cnt   <= rd_cnt + int'(mem_rden);
    done_cnt <= done_cnt + int'(fill_done);
    both_cnt <= both_cnt + int'(mem_wren & mem_rden);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [1:0] op, input logic [4:0] ba, input logic [1:0] by);
    int k = 0;
    req_write = w; req_addr = a; req_wdata = d; req_opcode = op;
    req_bitaddr = ba; req_byteaddr = by; req_valid = 1'b1;
    #1;
    while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
    check("req_accept", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k = 0;
    while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_addr", 64'(rsp_addr), 64'(a));
    check("rsp_data", 64'(rsp_data), 64'(d));
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!fill_done && k < 2 * NWORDS + 50) begin @(posedge clk); #1; k++; end
    check(tag, 64'(fill_done), 64'd1);
  endtask

  task automatic start_fill(input logic p);
    fill_pattern = p; fill_start = 1'b1;
    @(posedge clk); #1;
    fill_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    req_opcode = '0; req_bitaddr = '0; req_byteaddr = '0; rsp_ready = 0;
    fill_start = 0; fill_pattern = 0;

    // Reset held 3 cycles
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_outs", 64'({mem_wren, mem_rden, fill_busy, fill_done, mem_opcode, mem_bitaddr,
                          mem_byteaddr}), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wrbus", 64'(mem_wrbus), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);

    // Single write then read of the same address
    send(1'b1, AW'(16'h0005), 32'h1234_5678, 2'd0, 5'd0, 2'd0);
    check("wr_pins", 64'({mem_wren, mem_rden}), 64'b10);
    check("wr_addr", 64'(mem_addr), 64'h5);
    check("wr_data", 64'(mem_wrbus), 64'h1234_5678);
    send(1'b0, AW'(16'h0005), 32'h0, 2'd0, 5'd7, 2'd0);
    check("rd_pins", 64'({mem_wren, mem_rden}), 64'b01);
    check("rd_addr", 64'(mem_addr), 64'h5);
    check("rd_bitaddr", 64'(mem_bitaddr), 64'd7);
    @(posedge clk); #1;
    check("rd_one_cycle", 64'({mem_wren, mem_rden}), 64'b00);
    check("rd_lat_early1", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    check("rd_lat_early2", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    check("rd_lat_valid", 64'(rsp_valid), 64'd1);
    check("rd_rsp_data", 64'(rsp_data), 64'h1234_5678);
    check("rd_rsp_addr", 64'(rsp_addr), 64'h5);
    @(posedge clk); #1;
    check("rsp_hold", 64'({rsp_valid, rsp_data}), {31'd0, 1'b1, 32'h1234_5678});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rsp_popped", 64'(rsp_valid), 64'd0);
    rsp_ready = 1'b0;

    // Eight back-to-back reads against a stalled consumer
    for (int i = 0; i < 8; i++) send(1'b1, AW'(16'h0100 + i), 32'hA000_0000 + i, 2'd0, 5'd0, 2'd0);
    acc = 0;
    req_valid = 1'b1; req_write = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_addr = AW'(16'h0100 + acc);
      #1;
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    #1;
    check("burst_accepted", 64'(acc), 64'(RSP_DEPTH));
    check("burst_ready_low", 64'(req_ready), 64'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) get_rsp(AW'(16'h0100 + i), 32'hA000_0000 + i);
    rsp_ready = 1'b0;
    #1;
    check("burst_ready_back", 64'(req_ready), 64'd1);
    for (int i = 4; i < 8; i++) send(1'b0, AW'(16'h0100 + i), 32'h0, 2'd1, 5'd0, 2'd2);
    check("rd_opcode", 64'({mem_opcode, mem_byteaddr}), 64'b0110);
    rsp_ready = 1'b1;
    for (int i = 4; i < 8; i++) get_rsp(AW'(16'h0100 + i), 32'hA000_0000 + i);
    rsp_ready = 1'b0;

    // Reset while a read is in flight
    send(1'b0, AW'(16'h0005), 32'h0, 2'd0, 5'd0, 2'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rstrd_req_ready", 64'(req_ready), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    check("rstrd_no_rsp", 64'(rsp_valid), 64'd0);

    // Pattern-0 fill colliding with a write request: fill wins
    snap_wr = wr_cnt; snap_done = done_cnt;
    fill_pattern = 1'b0; fill_start = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(16'h0077); req_wdata = 32'hDEAD_BEEF;
    #1;
    check("fill_ready_drop", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    fill_start = 1'b0; req_valid = 1'b0;
    check("fill_busy", 64'(fill_busy), 64'd1);
    check("fill_req_rejected", 64'(mem_wren), 64'd0);
    wait_done("fill0_done");
    check("fill0_last_addr", 64'(mem_addr), 64'(NWORDS - 1));
    @(posedge clk); #1;
    check("fill0_done_pulse", 64'({fill_done, fill_busy}), 64'd0);
    check("fill0_writes", 64'(wr_cnt - snap_wr), 64'(NWORDS));
    check("fill0_done_cnt", 64'(done_cnt - snap_done), 64'd1);
    check("fill0_mem_top", 64'(mem[NWORDS-1]), 64'(NWORDS - 1));
    check("fill0_mem_77", 64'(mem[16'h0077 % NWORDS]), 64'(16'h0077 % NWORDS));
    check("fill0_err", 64'(err_count), 64'd0);
    check("fill0_ready", 64'(req_ready), 64'd1);

`ifdef MEM_REQ_SEQ_READBACK_EN
    // Walking-one fill with one corrupted read-back word, then a clean run
    corrupt = 1'b1;
    start_fill(1'b1);
    wait_done("walk_corrupt_done");
    @(posedge clk); #1;
    check("walk_err_one", 64'(err_count), 64'd1);
    check("walk_mem_25", 64'(mem[8'h25]), 64'h0000_0020);
    check("walk_mem_40", 64'(mem[8'h40]), 64'h0000_0001);
    corrupt = 1'b0;
    start_fill(1'b1);
    check("walk_err_cleared", 64'(err_count), 64'd0);
    wait_done("walk_clean_done");
    @(posedge clk); #1;
    check("walk_err_zero", 64'(err_count), 64'd0);
    check("walk_busy_low", 64'(fill_busy), 64'd0);
`endif

    // Reset in the middle of a fill
    start_fill(1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("midfill_busy", 64'(fill_busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    snap_done = done_cnt;
    check("midfill_req_ready", 64'(req_ready), 64'd1);
    check("midfill_idle", 64'({fill_busy, mem_wren}), 64'd0);
    n = 0;
    repeat (10) begin @(posedge clk); #1; n += int'(fill_done); end
    check("midfill_no_done", 64'(n + done_cnt - snap_done), 64'd0);

    check("never_wr_and_rd", 64'(both_cnt), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
